// File: rtl/edge_gen_pkg.sv
// rtl/edge_gen_pkg.sv - shared types and constants for the edge pulse generator
package edge_gen_pkg;

    localparam int DEF_CNT_W = 8;
    localparam int MIN_PHASE = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/phase_counter.sv
// rtl/phase_counter.sv - loadable down-counter with count==1 flag
module phase_counter
    import edge_gen_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_last
);

    logic [CNT_W-1:0] r_count;

    // Load has priority; the controller never decrements past 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_last = (r_count == CNT_W'(1));

endmodule

// File: rtl/edge_pulse_gen.sv
// rtl/edge_pulse_gen.sv - programmable N-pulse train generator (FSM and output registers)
module edge_pulse_gen
    import edge_gen_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] low_len,
    input  logic [CNT_W-1:0] num_pulses,
    output logic             d_out,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    logic [CNT_W-1:0] r_high;
    logic [CNT_W-1:0] r_low;

    logic [CNT_W-1:0] w_h_in;
    logic [CNT_W-1:0] w_l_in;
    logic             w_go;
    logic             w_ph_load;
    logic [CNT_W-1:0] w_ph_val;
    logic             w_ph_dec;
    logic             w_ph_last;
    logic             w_np_load;
    logic             w_np_dec;
    logic             w_np_last;

    assign w_h_in = (high_len == '0) ? CNT_W'(MIN_PHASE) : high_len;
    assign w_l_in = (low_len  == '0) ? CNT_W'(MIN_PHASE) : low_len;
    assign w_go   = start && !abort && (num_pulses != '0);

    always_comb begin
        w_ph_load = 1'b0;
        w_ph_val  = r_high;
        w_ph_dec  = 1'b0;
        w_np_load = 1'b0;
        w_np_dec  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_go) begin
                    w_ph_load = 1'b1;
                    w_ph_val  = w_h_in;
                    w_np_load = 1'b1;
                end
            end
            HIGH: begin
                if (!abort) begin
                    if (w_ph_last) begin
                        w_ph_load = 1'b1;
                        w_ph_val  = r_low;
                    end else begin
                        w_ph_dec  = 1'b1;
                    end
                end
            end
            LOW: begin
                if (!abort) begin
                    if (w_ph_last) begin
                        if (!w_np_last) begin
                            w_np_dec  = 1'b1;
                            w_ph_load = 1'b1;
                            w_ph_val  = r_high;
                        end
                    end else begin
                        w_ph_dec = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    phase_counter #(.CNT_W(CNT_W)) u_phase_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_ph_load),
        .i_load_val (w_ph_val),
        .i_dec      (w_ph_dec),
        .o_last     (w_ph_last)
    );

    phase_counter #(.CNT_W(CNT_W)) u_pulse_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_np_load),
        .i_load_val (num_pulses),
        .i_dec      (w_np_dec),
        .o_last     (w_np_last)
    );

    // done is a one-cycle strobe: cleared every cycle unless re-raised below.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_high  <= '0;
            r_low   <= '0;
            d_out   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !abort) begin
                        if (num_pulses != '0) begin
                            r_high  <= w_h_in;
                            r_low   <= w_l_in;
                            r_state <= HIGH;
                            d_out   <= 1'b1;
                            busy    <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (abort) begin
                        r_state <= IDLE;
                        d_out   <= 1'b0;
                        busy    <= 1'b0;
                    end else if (w_ph_last) begin
                        r_state <= LOW;
                        d_out   <= 1'b0;
                    end
                end
                LOW: begin
                    if (abort) begin
                        r_state <= IDLE;
                        d_out   <= 1'b0;
                        busy    <= 1'b0;
                    end else if (w_ph_last) begin
                        if (w_np_last) begin
                            r_state <= IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_state <= HIGH;
                            d_out   <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    d_out   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_pulse_gen.sv
// tb/tb_edge_pulse_gen.sv - scoreboard bench for edge_pulse_gen
module tb_edge_pulse_gen;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] low_len;
    logic [CNT_W-1:0] num_pulses;
    logic             d_out;
    logic             busy;
    logic             done;

    typedef struct packed {
        logic d;
        logic b;
        logic dn;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rises = 0;
    logic prev_d = 1'b0;

    edge_pulse_gen #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .high_len   (high_len),
        .low_len    (low_len),
        .num_pulses (num_pulses),
        .d_out      (d_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic d, input logic b, input logic dn);
        exp_t e;
        e.d = d; e.b = b; e.dn = dn;
        q.push_back(e);
    endtask

    // Expected waveform derived from the timing rules: H high, L low per pulse, then done.
    task automatic push_train(input int h, input int l, input int n);
        int he = (h == 0) ? 1 : h;
        int le = (l == 0) ? 1 : l;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < he; i++) push(1'b1, 1'b1, 1'b0);
            for (int i = 0; i < le; i++) push(1'b0, 1'b1, 1'b0);
        end
        push(1'b0, 1'b0, 1'b1);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        e = '0;
        if (q.size() != 0) e = q.pop_front();
        chk("d_out", int'(d_out), int'(e.d));
        chk("busy",  int'(busy),  int'(e.b));
        chk("done",  int'(done),  int'(e.dn));
        if (d_out && !prev_d) rises++;
        prev_d = d_out;
    endtask

    task automatic drain(input int budget);
        int left = budget;
        while (q.size() != 0 && left > 0) begin
            step();
            left--;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    task automatic drive_start(input int h, input int l, input int n);
        high_len   = CNT_W'(h);
        low_len    = CNT_W'(l);
        num_pulses = CNT_W'(n);
        start      = 1'b1;
    endtask

    task automatic run_train(input int h, input int l, input int n);
        rises = 0;
        drive_start(h, l, n);
        push_train(h, l, n);
        step();
        high_len   = 8'd9;
        low_len    = 8'd9;
        num_pulses = 8'd1;
        drain(2000);
        chk("rises", rises, n);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        high_len = '0; low_len = '0; num_pulses = '0;
        #3;
        chk("rst_d_out", int'(d_out), 0);
        chk("rst_busy",  int'(busy),  0);
        chk("rst_done",  int'(done),  0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) step();

        run_train(2, 3, 4);
        run_train(0, 0, 3);

        drive_start(5, 5, 0);
        push(1'b0, 1'b0, 1'b1);
        push(1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0);
        drain(10);

        rises = 0;
        drive_start(4, 4, 5);
        for (int i = 0; i < 4; i++) push(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) push(1'b0, 1'b1, 1'b0);
        push(1'b1, 1'b1, 1'b0);
        push(1'b1, 1'b1, 1'b0);
        drain(20);
        abort = 1'b1;
        push(1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0);
        drain(5);
        chk("abort_rises", rises, 2);
        run_train(1, 2, 3);

        rises = 0;
        drive_start(3, 2, 2);
        push_train(3, 2, 2);
        step();
        step();
        drive_start(1, 1, 7);
        step();
        drain(50);
        chk("busy_start_rises", rises, 2);
        drive_start(2, 2, 2);
        abort = 1'b1;
        push(1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0);
        drain(5);

        drive_start(2, 3, 4);
        push_train(2, 3, 4);
        step();
        step();
        step();
        chk("pre_rst_d_out", int'(d_out), 0);
        chk("pre_rst_busy",  int'(busy),  1);
        rst = 1'b0;
        #1;
        chk("mid_rst_d_out", int'(d_out), 0);
        chk("mid_rst_busy",  int'(busy),  0);
        chk("mid_rst_done",  int'(done),  0);
        q.delete();
        prev_d = 1'b0;
        step();
        rst = 1'b1;
        step();
        run_train(2, 3, 4);
        for (int i = 0; i < 3; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/edge_pulse_gen.md
# edge_pulse_gen

- Programmable pulse-train transmitter: the driving end of the rising-edge detector link.
- On a start request, `edge_pulse_gen` emits exactly N rising edges on `d_out`.
- Each pulse has a programmable high width and low width, so the downstream edge detector produces exactly N single-cycle detections.
- Sits in front of the edge-detector path; also serves as the stimulus source for that path in system benches.

## Interface
Parameters:
- CNT_W, default 8: width of the high-length, low-length and pulse-count fields and of the internal counters.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a pulse train; sampled only in IDLE.
- abort  input  1  synchronous cancel of a running train.
- high_len  input  CNT_W  high-phase width in cycles; 0 is treated as 1.
- low_len  input  CNT_W  low-phase width in cycles; 0 is treated as 1.
- num_pulses  input  CNT_W  number of pulses (rising edges) to emit.
- d_out  output  1  generated waveform, registered.
- busy  output  1  high while a train is in progress, registered.
- done  output  1  single-cycle completion strobe, registered.

## Operation
- Reset (rst=0, asynchronous): state=IDLE, all counters 0, d_out=0, busy=0, done=0.
- States: IDLE, HIGH, LOW.
- IDLE:
  - start=1 and num_pulses≠0 latch H=max(high_len,1), L=max(low_len,1), N=num_pulses, then go to HIGH.
  - start=1 and num_pulses=0: no pulses, stay IDLE, done=1 for one cycle.
- HIGH: d_out=1 for exactly H cycles, then go to LOW.
- LOW: d_out=0 for exactly L cycles. Then, if pulses remaining >1, decrement and return to HIGH; otherwise return to IDLE with done=1 for one cycle.
- The final pulse is always followed by its full L low cycles, so back-to-back trains keep at least one low cycle between edges.
- Config inputs are ignored after latching; changing them mid-train has no effect.
- start while busy=1 is ignored (not queued).
- abort=1 in HIGH or LOW: next edge goes to IDLE, d_out=0, busy=0, done stays 0.
- abort=1 in IDLE has no effect; if start=1 in the same cycle, abort wins and the start is dropped.
- A mid-train reset forces the reset values immediately (asynchronous).
- Counter arithmetic is CNT_W-bit unsigned down-counting; no wrap is possible, since counters are loaded from nonzero values and stop at 1.
- Maximum train length: N=2^CNT_W−1 pulses, each up to (2^CNT_W−1)×2 cycles.

## Timing
- Start sampled at edge T: d_out and busy are 1 from edge T+1.
- First pulse: d_out high for edges T+1 .. T+H, low from edge T+H+1.
- Pulse k (k from 0) rises at edge T+1+k(H+L).
- Completion: done=1 and busy=0 at edge T+1+N(H+L), with done high for one cycle. A new start is accepted in that same cycle.
- Minimum period is 2 cycles (H=L=1), giving a 50% square wave.
- The downstream edge detector asserts one cycle after each rise, i.e. N detections per train.

## Structure
- Package `edge_gen_pkg`:
  - state enum {IDLE, HIGH, LOW};
  - default CNT_W constant;
  - helper constant for the minimum phase length (1).
- One natural sub-module, `phase_counter`:
  - loadable CNT_W down-counter with load value, load enable and `last` flag (count==1);
  - instantiated for phase length and pulse count.
- The top level holds the FSM and output registers.

## Test plan
- Basic train: H=2, L=3, N=4, start at edge 10 → rises at edges 11, 16, 21, 26; done=1 at edge 31; exactly 4 detections from the downstream detector.
- Zero lengths: high_len=0, low_len=0, N=3 → 1-high/1-low square wave, 3 rises, done 6 cycles after start+1.
- num_pulses=0 with start → d_out stays 0, busy stays 0, done=1 for one cycle at the next edge.
- Abort mid-HIGH of the 2nd pulse (H=4, L=4, N=5) → d_out=0 and busy=0 next edge, no done; a subsequent start runs a full train.
- Start while busy, and start together with abort in IDLE → both ignored, waveform unchanged, no extra pulses.
- Reset asserted mid-LOW → d_out, busy, done immediately 0 and state IDLE; after release, a new start behaves per basic-train timing.
